fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the word-aligned PC loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request valid.
REQ-005 SHALL have port imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-006 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_rvalid  input  1  response data valid.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port stall  input  1  decode/control stage cannot accept the held instruction.
REQ-010 SHALL have port redirect  input  1  taken jump/branch (PCSrc) for the held instruction.
REQ-011 SHALL have port redirect_pc  input  32  jump/branch target.
REQ-012 SHALL have port instr_valid  output  1  instr/pc outputs hold a live instruction.
REQ-013 SHALL have port instr  output  32  held instruction word.
REQ-014 SHALL have port pc, pc_plus4  output  32 each  held instruction address and address+4.
REQ-015 SHALL have ports op  output  7 (instr[6:0]), funct3  output  3 (instr[14:12]), funct7  output  1 (instr[30]).
REQ-016 SHALL have port misaligned  output  1  sticky: a redirect target was not word-aligned.

Function
REQ-017 SHALL implement FSM states FETCH, WAIT, DROP, HALT, plus a fetch_pc register and a one-entry instruction buffer.
REQ-018 Consume: instruction consumed when instr_valid=1 and stall=0; redirect is honoured only when consumed (redirect_taken).
REQ-019 FETCH: imem_req=1, imem_addr=fetch_pc, only when buffer empty or being consumed and redirect_taken=0; otherwise imem_req=0.
REQ-020 FETCH->WAIT on imem_req & imem_gnt; at most one request outstanding at any time.
REQ-021 WAIT on imem_rvalid: buffer loads instr=imem_rdata, pc=fetch_pc, instr_valid=1 next cycle; fetch_pc+=4; ->FETCH.
REQ-022 Latency: grant in cycle N, rvalid in cycle N+k (k>=1), instr_valid=1 in cycle N+k+1.
REQ-023 Buffer SHALL hold instr/pc/instr_valid stable while stall=1; consumption without a same-cycle reload clears instr_valid.
REQ-024 redirect_taken with redirect_pc[1:0]==0: fetch_pc<=redirect_pc, instr_valid<=0; if in WAIT or granted this cycle ->DROP, else ->FETCH.
REQ-025 DROP: next imem_rvalid discarded (buffer untouched), ->FETCH issuing at redirected fetch_pc.
REQ-026 Redirect and imem_rvalid in same cycle: redirect wins, response discarded, no DROP needed.
REQ-027 redirect_taken with redirect_pc[1:0]!=0: misaligned<=1, instr_valid<=0, ->HALT; HALT issues no requests until reset.
REQ-028 imem_rvalid in FETCH or HALT SHALL be ignored.
REQ-029 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); pc_plus4 same rule.
REQ-030 op/funct3/funct7 SHALL be combinational slices of the held instr.

Reset
REQ-031 reset=1 at a rising edge SHALL set state=FETCH, fetch_pc=RESET_PC, instr_valid=0, instr=0, pc=RESET_PC, misaligned=0, discarding any outstanding request.
REQ-032 imem_req SHALL be 0 in every cycle reset=1; first request in the cycle after reset deasserts.
REQ-033 Reset mid-WAIT/DROP/HALT SHALL behave identically to REQ-031; late responses fall under REQ-028.

Verification
REQ-034 Reset, gnt=1, rvalid one cycle after grant, stall=0 -> imem_addr 0,4,8; instr_valid sequence pc=0,4,8 with pc_plus4=4,8,12.
REQ-035 stall=1 for 3 cycles with instr_valid=1 at pc=8 -> instr/pc unchanged, imem_req=0; after release next fetch addr=12.
REQ-036 redirect=1, redirect_pc=0x100 while request to 0x10 outstanding -> 0x10 response dropped, next imem_addr=0x100, next instr_valid pc=0x100.
REQ-037 redirect_pc=0x102 -> misaligned=1, instr_valid=0, imem_req stays 0 for 20 cycles; reset clears misaligned, fetch resumes at RESET_PC.
REQ-038 fetch_pc=0xFFFF_FFFC response -> pc_plus4=0, next imem_addr=0; reset asserted in WAIT then late rvalid -> ignored, instr_valid=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one outstanding memory request at a time and
// holds the returned word in a single-entry buffer until the decode stage consumes it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        misaligned
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP, HALT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        consume;
  logic        redirect_taken;
  logic        buf_free;
  logic        granted;
  logic        load;

  assign consume        = instr_valid & ~stall;
  assign redirect_taken = consume & redirect;
  assign buf_free       = ~instr_valid | consume;
  assign imem_req       = ~reset & (state == FETCH) & buf_free & ~redirect_taken;
  assign imem_addr      = fetch_pc;
  assign granted        = imem_req & imem_gnt;
  assign load           = (state == WAIT) & imem_rvalid & ~redirect_taken;

  assign pc_plus4 = pc + 32'd4;
  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[30];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      pc          <= RESET_PC;
      misaligned  <= 1'b0;
    end else begin
      if (consume) instr_valid <= 1'b0;

      case (state)
        FETCH: if (granted) state <= WAIT;
        WAIT: begin
          if (load) begin
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            fetch_pc    <= fetch_pc + 32'd4;
            state       <= FETCH;
          end
        end
        DROP: if (imem_rvalid) state <= FETCH;
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase

      // A response arriving alongside the redirect is simply not loaded, so no DROP is needed.
      if (redirect_taken) begin
        instr_valid <= 1'b0;
        if (redirect_pc[1:0] == 2'b00) begin
          fetch_pc <= redirect_pc;
          if (((state == WAIT) && !imem_rvalid) || granted) state <= DROP;
          else state <= FETCH;
        end else begin
          misaligned <= 1'b1;
          state      <= HALT;
        end
      end
    end
  end

endmodule
